// File: rtl/fcmp_pipe.sv
// fcmp_pipe -- two-stage IEEE-754 single-precision compare pipeline.
//
// Stage S1 registers the operand classification: signs, zero flags and the
// magnitude compare of x1[30:0] against x2[30:0]. Stage S2 registers the
// result (y), the destination tag and, optionally, the invalid flag. Each
// stage stalls independently with valid/ready flow control, so the pipe
// holds up to two operations and sustains one operation per cycle.
// Operands with a zero exponent are treated as zero of either sign, which
// flushes denormals.
//
// Optional feature macro: FCMP_NAN_CHECK_EN
//   defined   -> NaN operands force y=0 and raise nv for flt/fle, or for a
//                signalling NaN in feq; adds the nv output port.
//   undefined -> no nv port; NaN/Inf compare as plain sign-magnitude patterns.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               squash all in-flight operations
//   in_valid/in_ready   operation handshake (x1, x2, op, in_tag)
//   op                  00 feq, 01 flt, 10 fle, 11 reserved (y=0)
//   out_valid/out_ready result handshake (y, out_tag [, nv])

module fcmp_pipe #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [1:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y,
    output logic [TAG_W-1:0] out_tag
`ifdef FCMP_NAN_CHECK_EN
    ,
    output logic             nv
`endif
);

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // Stage S1: classification
    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_sgn1_q, s1_sgn1_d;
    logic             s1_sgn2_q, s1_sgn2_d;
    logic             s1_zero1_q, s1_zero1_d;
    logic             s1_zero2_q, s1_zero2_d;
    logic             s1_mag_lt_q, s1_mag_lt_d;
    logic             s1_mag_eq_q, s1_mag_eq_d;
`ifdef FCMP_NAN_CHECK_EN
    logic             s1_nan_q, s1_nan_d;
    logic             s1_snan_q, s1_snan_d;
`endif

    // Stage S2: result
    logic             s2_valid_q, s2_valid_d;
    logic             s2_y_q, s2_y_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
`ifdef FCMP_NAN_CHECK_EN
    logic             s2_nv_q, s2_nv_d;
`endif

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic res_y;
`ifdef FCMP_NAN_CHECK_EN
    logic res_nv;
`endif

    // Handshake
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !rst && !flush && (!s1_valid_q || s1_adv);
        accept   = in_valid && in_ready;
    end

    // S1 next state
    always_comb begin
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s1_sgn1_d   = s1_sgn1_q;
        s1_sgn2_d   = s1_sgn2_q;
        s1_zero1_d  = s1_zero1_q;
        s1_zero2_d  = s1_zero2_q;
        s1_mag_lt_d = s1_mag_lt_q;
        s1_mag_eq_d = s1_mag_eq_q;
`ifdef FCMP_NAN_CHECK_EN
        s1_nan_d    = s1_nan_q;
        s1_snan_d   = s1_snan_q;
`endif
        if (accept) begin
            s1_op_d     = op_e'(op);
            s1_tag_d    = in_tag;
            s1_sgn1_d   = x1[31];
            s1_sgn2_d   = x2[31];
            s1_zero1_d  = (x1[30:23] == 8'd0);
            s1_zero2_d  = (x2[30:23] == 8'd0);
            s1_mag_lt_d = (x1[30:0] < x2[30:0]);
            s1_mag_eq_d = (x1[30:0] == x2[30:0]);
`ifdef FCMP_NAN_CHECK_EN
            s1_nan_d    = ((&x1[30:23]) && (|x1[22:0])) ||
                          ((&x2[30:23]) && (|x2[22:0]));
            s1_snan_d   = ((&x1[30:23]) && (|x1[22:0]) && !x1[22]) ||
                          ((&x2[30:23]) && (|x2[22:0]) && !x2[22]);
`endif
        end

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Compare from S1 classification. Raw [30:0] magnitudes stay correct when
    // exactly one operand is a flushed denormal (its exponent field is 0 and
    // so orders below any normal); the both-zero case is handled explicitly.
    always_comb begin
        logic both_zero;
        logic is_eq;
        logic is_lt;
        both_zero = s1_zero1_q && s1_zero2_q;
        is_eq = both_zero ||
                (!s1_zero1_q && !s1_zero2_q &&
                 (s1_sgn1_q == s1_sgn2_q) && s1_mag_eq_q);
        if (both_zero) begin
            is_lt = 1'b0;
        end else if (s1_sgn1_q != s1_sgn2_q) begin
            is_lt = s1_sgn1_q;
        end else if (!s1_sgn1_q) begin
            is_lt = s1_mag_lt_q;
        end else begin
            is_lt = !s1_mag_lt_q && !s1_mag_eq_q;
        end

        case (s1_op_q)
            OP_FEQ:  res_y = is_eq;
            OP_FLT:  res_y = is_lt;
            OP_FLE:  res_y = is_lt || is_eq;
            default: res_y = 1'b0;
        endcase

`ifdef FCMP_NAN_CHECK_EN
        res_nv = 1'b0;
        if (s1_nan_q) begin
            res_y  = 1'b0;
            res_nv = (s1_op_q == OP_FLT) || (s1_op_q == OP_FLE) ||
                     ((s1_op_q == OP_FEQ) && s1_snan_q);
        end
`endif
    end

    // S2 next state
    always_comb begin
        s2_y_d   = s2_y_q;
        s2_tag_d = s2_tag_q;
`ifdef FCMP_NAN_CHECK_EN
        s2_nv_d  = s2_nv_q;
`endif
        if (s1_adv) begin
            s2_y_d   = res_y;
            s2_tag_d = s1_tag_q;
`ifdef FCMP_NAN_CHECK_EN
            s2_nv_d  = res_nv;
`endif
        end

        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_FEQ;
            s1_tag_q    <= '0;
            s1_sgn1_q   <= 1'b0;
            s1_sgn2_q   <= 1'b0;
            s1_zero1_q  <= 1'b0;
            s1_zero2_q  <= 1'b0;
            s1_mag_lt_q <= 1'b0;
            s1_mag_eq_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_y_q      <= 1'b0;
            s2_tag_q    <= '0;
`ifdef FCMP_NAN_CHECK_EN
            s1_nan_q    <= 1'b0;
            s1_snan_q   <= 1'b0;
            s2_nv_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s1_sgn1_q   <= s1_sgn1_d;
            s1_sgn2_q   <= s1_sgn2_d;
            s1_zero1_q  <= s1_zero1_d;
            s1_zero2_q  <= s1_zero2_d;
            s1_mag_lt_q <= s1_mag_lt_d;
            s1_mag_eq_q <= s1_mag_eq_d;
            s2_valid_q  <= s2_valid_d;
            s2_y_q      <= s2_y_d;
            s2_tag_q    <= s2_tag_d;
`ifdef FCMP_NAN_CHECK_EN
            s1_nan_q    <= s1_nan_d;
            s1_snan_q   <= s1_snan_d;
            s2_nv_q     <= s2_nv_d;
`endif
        end
    end

    // Outputs are forced low while rst is high, including the first reset
    // cycle before the synchronous clear has taken effect.
    always_comb begin
        out_valid = s2_valid_q && !rst;
        y         = s2_y_q && !rst;
        out_tag   = rst ? '0 : s2_tag_q;
`ifdef FCMP_NAN_CHECK_EN
        nv        = s2_nv_q && !rst;
`endif
    end

endmodule

// File: doc/fcmp_pipe.md
FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 SHALL have parameter: TAG_W, default 5, width of the destination-register tag carried alongside each operation.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  synchronous squash of all in-flight operations.
REQ-005 SHALL have port: in_valid  input  1  operation offered.
REQ-006 SHALL have port: in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-007 SHALL have ports: x1, x2  input  32 each  IEEE-754 single operands.
REQ-008 SHALL have port: op  input  2  operation select: 00 feq, 01 flt (x1<x2), 10 fle (x1<=x2), 11 reserved.
REQ-009 SHALL have port: in_tag  input  TAG_W  destination tag.
REQ-010 SHALL have port: out_valid  output  1  result present.
REQ-011 SHALL have port: out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port: y  output  1  comparison result.
REQ-013 SHALL have port: out_tag  output  TAG_W  tag of the result.
REQ-014 SHALL have port: nv  output  1  invalid flag; present only when FCMP_NAN_CHECK_EN is defined.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 registers operand classification (sign, zero flag, magnitude compare x1[30:0] vs x2[30:0]); S2 registers y, out_tag and nv.
REQ-016 SHALL produce out_valid exactly 2 cycles after acceptance while out_ready stays high; sustained throughput 1 op/cycle.
REQ-017 SHALL treat any operand with exponent 0 as zero of either sign (denormals flushed), so +0 == -0.
REQ-018 SHALL compute feq = both zero, or bit-identical after flushing; flt = sign-magnitude ordering with both zero giving 0; fle = flt || feq.
REQ-019 SHALL output y=0 for op=11.
REQ-020 SHALL stall per stage: a stage advances when its successor is empty or advancing; in_ready = !S1_valid || S1 advancing.
REQ-021 SHALL keep S2 contents (y, out_tag, nv) stable while out_valid && !out_ready.
REQ-022 SHALL hold at most 2 operations; with out_ready low, in_ready falls after the second acceptance and no operation is lost or reordered.
REQ-023 SHALL, on flush, clear both stage valid bits next cycle, drive in_ready low during the flush cycle, and accept nothing in that cycle.
REQ-024 SHALL allow acceptance and output consumption in the same cycle with both stages full and no bubble.

Reset
REQ-025 SHALL, while rst is high, clear S1/S2 valid, drive out_valid=0, y=0, out_tag=0, nv=0, in_ready=0.
REQ-026 SHALL drive in_ready=1 the first cycle after rst deasserts.
REQ-027 SHALL discard in-flight operations on reset mid-operation; reset has priority over flush and handshakes.

Configuration
REQ-028 SHALL use macro FCMP_NAN_CHECK_EN: defined -> any NaN operand (exp=255, mantissa!=0) forces y=0, and nv=1 for flt/fle or for a signalling NaN (mantissa[22]=0) in feq; otherwise nv=0.
REQ-029 SHALL, when FCMP_NAN_CHECK_EN is undefined, omit nv and compare NaN/Inf as ordinary sign-magnitude bit patterns.

Verification
REQ-030 SHALL test feq x1=00000000, x2=80000000, tag 3 -> y=1, out_tag=3, out_valid exactly 2 cycles after acceptance.
REQ-031 SHALL test flt 3F800000 vs 40000000 -> 1; swapped -> 0; BF800000 vs 3F800000 -> 1; fle 40490FDB vs 40490FDB -> 1; feq 00000001 vs 00000000 -> 1.
REQ-032 SHALL test back-to-back issue of 3 ops with out_ready low 4 cycles -> in_ready low after 2nd acceptance; on release, results in issue order, none lost.
REQ-033 SHALL test flush with 2 ops in flight plus in_valid=1 -> out_valid=0 next cycle; the offered op is not accepted.
REQ-034 SHALL test rst asserted with full pipeline -> all outputs 0; in_ready=1 the cycle after release.
REQ-035 SHALL test feq 7FC00000 vs 7FC00000 -> with FCMP_NAN_CHECK_EN: y=0, nv=0; flt of same pair: y=0, nv=1; without the macro: feq y=1.
